// File: rtl/adc_ro_pkg.sv
// Shared types and header layout for the multi-channel ADC readout block.
package adc_ro_pkg;

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_HEADER, S_DATA} state_e;

  localparam logic [3:0] HDR_MAGIC     = 4'hA;
  localparam int         FIELD_W       = 16;
  localparam int         HDR_MAGIC_LSB = 28;
  localparam int         HDR_RSVD_LSB  = 24;
  localparam int         HDR_HIT_LSB   = 16;
  localparam int         HDR_EVT_LSB   = 0;
  localparam int         HIT_EXT_BIT   = 7;

  // Width of a sample-pair index; never below one bit so WIN_LEN=2 still has a port.
  function automatic int pair_w(input int win);
    return (win > 2) ? $clog2(win / 2) : 1;
  endfunction

  function automatic logic [31:0] pack_header(input logic [7:0] hit, input logic [FIELD_W-1:0] evt);
    logic [31:0] w;
    w = '0;
    w[HDR_MAGIC_LSB +: 4]      = HDR_MAGIC;
    w[HDR_HIT_LSB +: 8]        = hit;
    w[HDR_EVT_LSB +: FIELD_W]  = evt;
    return w;
  endfunction

endpackage

// File: rtl/adc_ro_chbuf.sv
// Per-channel window buffer: one write port, asynchronous read of an even/odd sample pair.
module adc_ro_chbuf
  import adc_ro_pkg::*;
#(
  parameter int ADC_W   = 14,
  parameter int WIN_LEN = 16
) (
  input  logic                            clk_i,
  input  logic                            we_i,
  input  logic [$clog2(WIN_LEN)-1:0]      waddr_i,
  input  logic [ADC_W-1:0]                wdata_i,
  input  logic [pair_w(WIN_LEN)-1:0]      raddr_i,
  output logic [2*ADC_W-1:0]              rdata_o
);

  localparam int AW = $clog2(WIN_LEN);

  logic [ADC_W-1:0] mem [WIN_LEN];
  logic [AW-1:0]    ra_lo, ra_hi;

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  assign ra_lo   = AW'({raddr_i, 1'b0});
  assign ra_hi   = AW'({raddr_i, 1'b1});
  assign rdata_o = {mem[ra_hi], mem[ra_lo]};

endmodule

// File: rtl/adc_multi_ro.sv
// Triggered multi-channel ADC window capture with Avalon-style header+data word stream.
module adc_multi_ro
  import adc_ro_pkg::*;
#(
  parameter int NCH     = 2,
  parameter int ADC_W   = 14,
  parameter int WIN_LEN = 16
) (
  input  logic                   clk_clk,
  input  logic                   reset_reset_n,
  input  logic [NCH*ADC_W-1:0]   adc_data,
  input  logic                   adc_valid,
  input  logic                   enable,
  input  logic [ADC_W-1:0]       thresh,
  input  logic [NCH-1:0]         trg_mask,
  input  logic                   ext_trg,
  output logic [31:0]            out_writedata,
  output logic                   out_write,
  input  logic                   out_waitrequest,
  output logic                   busy,
  output logic [15:0]            evt_count,
  output logic [15:0]            drop_count
);

  localparam int AW    = $clog2(WIN_LEN);
  localparam int PW    = pair_w(WIN_LEN);
  localparam int NPAIR = WIN_LEN / 2;
  localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1;

  state_e                       state_q, state_d;
  logic [AW-1:0]                wcnt_q, wcnt_d;
  logic [CW-1:0]                ch_q, ch_d, rd_ch;
  logic [PW-1:0]                pr_q, pr_d, rd_pr;
  logic [7:0]                   hit_q, hit_d;
  logic                         wr_q, wr_d;
  logic [31:0]                  wd_q, wd_d;
  logic [15:0]                  evt_q, evt_d;
  logic [15:0]                  drop_q, drop_d;

  logic [NCH-1:0]               ch_hit;
  logic                         trig, accept, last_pair, last_word, buf_we;
  logic [AW-1:0]                buf_waddr;
  logic [NCH-1:0][2*ADC_W-1:0]  rdata;
  logic [2*ADC_W-1:0]           sel;
  logic [FIELD_W-1:0]           lo16, hi16;
  logic [31:0]                  data_word;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    assign ch_hit[c] = trg_mask[c] & (adc_data[c*ADC_W +: ADC_W] > thresh);

    adc_ro_chbuf #(.ADC_W(ADC_W), .WIN_LEN(WIN_LEN)) u_buf (
      .clk_i   (clk_clk),
      .we_i    (buf_we),
      .waddr_i (buf_waddr),
      .wdata_i (adc_data[c*ADC_W +: ADC_W]),
      .raddr_i (rd_pr),
      .rdata_o (rdata[c])
    );
  end

  assign trig      = adc_valid & (ext_trg | (|ch_hit));
  assign accept    = wr_q & ~out_waitrequest;
  assign last_pair = (pr_q == PW'(NPAIR - 1));
  assign last_word = last_pair && (ch_q == CW'(NCH - 1));
  assign buf_we    = (state_q == S_IDLE) ? (enable & trig) : ((state_q == S_CAPTURE) & adc_valid);
  assign buf_waddr = (state_q == S_IDLE) ? '0 : wcnt_q;

  // Address of the word to present after the current one is accepted.
  always_comb begin
    rd_ch = ch_q;
    rd_pr = pr_q + 1'b1;
    if (state_q != S_DATA) begin
      rd_ch = '0;
      rd_pr = '0;
    end else if (last_pair) begin
      rd_ch = ch_q + 1'b1;
      rd_pr = '0;
    end
  end

  always_comb begin
    sel  = rdata[rd_ch];
    lo16 = '0;
    hi16 = '0;
    lo16[ADC_W-1:0] = sel[ADC_W-1:0];
    hi16[ADC_W-1:0] = sel[2*ADC_W-1:ADC_W];
    data_word = {hi16, lo16};
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    ch_d    = ch_q;
    pr_d    = pr_q;
    hit_d   = hit_q;
    wr_d    = wr_q;
    wd_d    = wd_q;
    evt_d   = evt_q;
    drop_d  = drop_q;
    if ((state_q != S_IDLE) && trig && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
    unique case (state_q)
      S_IDLE: if (enable && trig) begin
        hit_d              = '0;
        hit_d[NCH-1:0]     = ch_hit;
        hit_d[HIT_EXT_BIT] = ext_trg;
        wcnt_d             = AW'(1);
        state_d            = S_CAPTURE;
      end
      S_CAPTURE: if (adc_valid) begin
        wcnt_d = wcnt_q + 1'b1;
        if (wcnt_q == AW'(WIN_LEN - 1)) begin
          // evt_q cannot move between trigger and here, so it is the count at trigger.
          state_d = S_HEADER;
          wr_d    = 1'b1;
          wd_d    = pack_header(hit_q, evt_q);
        end
      end
      S_HEADER: if (accept) begin
        evt_d   = evt_q + 16'd1;
        ch_d    = rd_ch;
        pr_d    = rd_pr;
        wd_d    = data_word;
        state_d = S_DATA;
      end
      S_DATA: if (accept) begin
        if (last_word) begin
          wr_d    = 1'b0;
          wd_d    = '0;
          state_d = S_IDLE;
        end else begin
          ch_d = rd_ch;
          pr_d = rd_pr;
          wd_d = data_word;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      ch_q    <= '0;
      pr_q    <= '0;
      hit_q   <= '0;
      wr_q    <= 1'b0;
      wd_q    <= '0;
      evt_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      ch_q    <= ch_d;
      pr_q    <= pr_d;
      hit_q   <= hit_d;
      wr_q    <= wr_d;
      wd_q    <= wd_d;
      evt_q   <= evt_d;
      drop_q  <= drop_d;
    end
  end

  assign out_write     = wr_q;
  assign out_writedata = wd_q;
  assign busy          = (state_q != S_IDLE);
  assign evt_count     = evt_q;
  assign drop_count    = drop_q;

endmodule

// File: tb/tb_adc_multi_ro.sv
// Table-driven events with a word scoreboard, plus hand sequences for backpressure, drops and reset.
module tb_adc_multi_ro;

  localparam int NCH = 2, ADC_W = 14, WIN_LEN = 4;
  localparam logic [13:0] THR = 14'd100;

  logic                 clk, rst_n;
  logic [NCH*ADC_W-1:0] adc_data;
  logic                 adc_valid, enable, ext_trg, out_write, out_waitrequest, busy;
  logic [ADC_W-1:0]     thresh;
  logic [NCH-1:0]       trg_mask;
  logic [31:0]          out_writedata;
  logic [15:0]          evt_count, drop_count;

  adc_multi_ro #(.NCH(NCH), .ADC_W(ADC_W), .WIN_LEN(WIN_LEN)) dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .adc_data(adc_data), .adc_valid(adc_valid),
    .enable(enable), .thresh(thresh), .trg_mask(trg_mask), .ext_trg(ext_trg),
    .out_writedata(out_writedata), .out_write(out_write), .out_waitrequest(out_waitrequest),
    .busy(busy), .evt_count(evt_count), .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0][13:0] s0;
    logic [3:0][13:0] s1;
    logic [1:0]       mask;
    logic             ext;
    logic [7:0]       hit;
    int               gap;
  } vec_t;

  vec_t        tbl[5];
  logic [31:0] sb[$];
  int          pass_cnt = 0, total_cnt = 0;
  int          exp_evt = 0, exp_drop = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  function automatic int sat(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  function automatic bit model_trig(input vec_t v, input int k, input logic ext);
    return ext | (v.mask[0] && v.s0[k] > THR) | (v.mask[1] && v.s1[k] > THR);
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_write && !out_waitrequest) begin
      if (sb.size() == 0) begin
        total_cnt++;
        $display("FAIL spurious_word: got %h want none", out_writedata);
      end else begin
        chk("word", out_writedata, sb.pop_front());
      end
    end
  end

  task automatic send_event(input vec_t v);
    logic [13:0] lo, hi;
    sb.push_back({4'hA, 4'h0, v.hit, exp_evt[15:0]});
    for (int c = 0; c < NCH; c++)
      for (int k = 0; k < WIN_LEN; k += 2) begin
        lo = (c == 0) ? v.s0[k]   : v.s1[k];
        hi = (c == 0) ? v.s0[k+1] : v.s1[k+1];
        sb.push_back({2'b00, hi, 2'b00, lo});
      end
    trg_mask = v.mask;
    for (int k = 0; k < WIN_LEN; k++) begin
      adc_data  = {v.s1[k], v.s0[k]};
      ext_trg   = (k == 0) ? v.ext : 1'b0;
      adc_valid = 1'b1;
      if (k > 0 && model_trig(v, k, 1'b0)) exp_drop = sat(exp_drop + 1);
      @(posedge clk); #1;
      adc_valid = 1'b0;
      ext_trg   = 1'b0;
      if (k < WIN_LEN - 1) repeat (v.gap) begin @(posedge clk); #1; end
    end
    chk("hdr_next_cycle", {31'b0, out_write}, 32'd1);
  endtask

  task automatic wait_done();
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy) begin ok = 1'b1; break; end
    end
    chk("drain", {31'b0, ok}, 32'd1);
    exp_evt++;
    chk("evt_count", {16'b0, evt_count}, exp_evt);
    chk("drop_count", {16'b0, drop_count}, exp_drop);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{s0: {14'd104, 14'd103, 14'd102, 14'd101}, s1: {14'd8, 14'd7, 14'd6, 14'd5},
               mask: 2'b01, ext: 1'b0, hit: 8'h01, gap: 0};
    tbl[1] = '{s0: {14'd70, 14'd60, 14'd50, 14'd100}, s1: {14'd3, 14'd2, 14'd1, 14'd100},
               mask: 2'b11, ext: 1'b1, hit: 8'h80, gap: 0};
    tbl[2] = '{s0: {14'd3, 14'd2, 14'd1, 14'd200}, s1: {14'd6, 14'd5, 14'd4, 14'd16383},
               mask: 2'b11, ext: 1'b1, hit: 8'h83, gap: 2};
    tbl[3] = '{s0: {14'd500, 14'd500, 14'd500, 14'd500}, s1: {14'd9, 14'd8, 14'd7, 14'd101},
               mask: 2'b10, ext: 1'b0, hit: 8'h02, gap: 1};
    tbl[4] = '{s0: {14'd4, 14'd3, 14'd2, 14'd1}, s1: {14'd40, 14'd30, 14'd20, 14'd10},
               mask: 2'b11, ext: 1'b1, hit: 8'h80, gap: 0};

    rst_n = 1'b0; adc_data = '0; adc_valid = 1'b0; enable = 1'b1; thresh = THR;
    trg_mask = '0; ext_trg = 1'b0; out_waitrequest = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_write", {31'b0, out_write}, 32'd0);
    chk("rst_wdata", out_writedata, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_evt", {16'b0, evt_count}, 32'd0);
    chk("rst_drop", {16'b0, drop_count}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) begin
      send_event(tbl[i]);
      wait_done();
      @(posedge clk); #1;
    end

    // disabled: trigger neither captured nor counted
    enable = 1'b0; trg_mask = 2'b01; adc_data = {14'd0, 14'd900}; adc_valid = 1'b1;
    @(posedge clk); #1; adc_valid = 1'b0;
    @(negedge clk);
    chk("disabled_busy", {31'b0, busy}, 32'd0);
    chk("disabled_drop", {16'b0, drop_count}, exp_drop);
    enable = 1'b1;
    @(posedge clk); #1;

    // backpressure on the second word
    send_event(tbl[0]);
    @(posedge clk); #1;
    out_waitrequest = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_write", {31'b0, out_write}, 32'd1);
      chk("bp_wdata", out_writedata, 32'h0066_0065);
    end
    @(posedge clk); #1;
    out_waitrequest = 1'b0;
    wait_done();
    @(posedge clk); #1;

    // triggers during DATA with enable dropped mid-event
    send_event(tbl[3]);
    @(posedge clk); #1;
    out_waitrequest = 1'b1; enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      adc_data = {14'd1, 14'd1}; ext_trg = 1'b1; adc_valid = 1'b1;
      @(posedge clk); #1;
    end
    adc_valid = 1'b0; ext_trg = 1'b0; out_waitrequest = 1'b0;
    exp_drop = sat(exp_drop + 5);
    wait_done();
    enable = 1'b1;
    @(posedge clk); #1;

    // drop_count saturation while stalled on the header
    send_event(tbl[1]);
    out_waitrequest = 1'b1; adc_valid = 1'b1; ext_trg = 1'b1;
    repeat (65540) @(posedge clk);
    #1;
    adc_valid = 1'b0; ext_trg = 1'b0;
    chk("drop_sat", {16'b0, drop_count}, 32'h0000_FFFF);
    out_waitrequest = 1'b0;
    exp_drop = 65535;
    wait_done();
    @(posedge clk); #1;

    // reset mid-DATA
    send_event(tbl[0]);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_write", {31'b0, out_write}, 32'd0);
    chk("midrst_wdata", out_writedata, 32'd0);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_evt", {16'b0, evt_count}, 32'd0);
    chk("midrst_drop", {16'b0, drop_count}, 32'd0);
    sb.delete();
    exp_evt = 0; exp_drop = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_evt", {16'b0, evt_count}, 32'd0);
    send_event(tbl[4]);
    wait_done();

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
